uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Receive-side frame controller for the UART RX path. It detects the start bit and gates the external edge/bit counter through counter_en. It samples RX_IN at mid-bit points derived from prescaler and deserializes data LSB-first. It checks the optional parity bit and the stop bit, then presents the received byte with a one-cycle valid pulse or an error pulse. It sits between the RX pin synchronizer and the RX FIFO/register-file writer.

Parameters:
DATA_WIDTH, 8, data bits per frame. Legal range 5..10, bounded so that 1 + DATA_WIDTH + 1 + 1 <= 15 fits the 4-bit bit counter.
PRESC_W, 6, width of prescaler and edge_counter.
BCNT_W, 4, width of bit_counter.

Ports:
CLK  in  1  system clock. One clock domain; all logic on rising edge.
RST  in  1  synchronous, active-high reset.
RX_IN  in  1  serial input, already synchronized; idle high.
PAR_EN  in  1  1 = parity bit present after data.
PAR_TYP  in  1  0 = even, 1 = odd.
prescaler  in  PRESC_W  oversampling ratio, cycles per bit. Supported: 8, 16, 32; minimum legal 4.
edge_counter  in  PRESC_W  from edge/bit counter; counts 1..prescaler.
bit_counter  in  BCNT_W  from edge/bit counter; 1 = start bit.
counter_en  out  1  enable to edge/bit counter. While low, the counter holds both counts at 1.
P_DATA  out  DATA_WIDTH  last good received word.
data_valid  out  1  one-cycle pulse, P_DATA updated.
par_err  out  1  one-cycle pulse, parity mismatch.
stp_err  out  1  one-cycle pulse, stop bit sampled 0.
busy  out  1  high when state != IDLE.

Behaviour:
- Reset (RST=1 at a clock edge): state=IDLE, shift register=0, P_DATA=0. data_valid, par_err, stp_err are 0. Reset mid-frame aborts immediately; no pulses are issued.
- counter_en = (state != IDLE), combinational from the state register. busy is identical.
- Sample point: SP = prescaler>>1. The sampled bit is registered when edge_counter==SP.
- End-of-bit (EOB) = edge_counter==prescaler. On EOB the counter increments bit_counter.
- State IDLE: RX_IN==0 at a clock edge moves to START. The counters start at edge_counter=1, bit_counter=1.
- State START: at EOB, a sampled value of 1 means a glitch. The FSM returns to IDLE silently with no pulse; otherwise it moves to DATA.
- State DATA: each sample shifts in LSB-first (shift = {sample, shift[DATA_WIDTH-1:1]}). Data bit i is at bit_counter = i+2. At EOB with bit_counter==DATA_WIDTH+1, go to PARITY if PAR_EN else STOP.
- State PARITY: sample the bit. At EOB, flag a mismatch if sample != (^shift ^ PAR_TYP). Hold the flag internally, then go to STOP.
- State STOP: sample the bit. At EOB go to IDLE and register the result:
  - stop sample 0 → stp_err=1.
  - parity flag set → par_err=1.
  - both errors may assert in the same cycle.
  - no error → P_DATA<=shift, data_valid=1.
  - pulses last exactly one cycle. P_DATA is unchanged on any error.
- Latency: let t be the edge that first samples RX_IN=0. Pulses go high after edge t + N·prescaler, where N = DATA_WIDTH+2, plus 1 if PAR_EN.
- Back-to-back frames: one IDLE cycle is mandatory. During it counter_en=0 and the counters reset. If RX_IN is low in that IDLE cycle, START is entered on the next edge.
- PAR_EN, PAR_TYP and prescaler must be static while busy=1. Changes take effect only on the next frame.

Optional Feature:
UART_RX_MAJORITY_VOTE_EN
- Defined: three samples at edge_counter SP-1, SP, SP+1. The bit value is the 2-of-3 majority, resolved at SP+1, and that value is used for shifting, parity and stop checks.
- Undefined: single sample at SP. No extra sample registers.

Decomposition:
- Package uart_rx_pkg holds:
  - the state enum: IDLE, START, DATA, PARITY, STOP;
  - constants START_IDX=1 and FIRST_DATA_IDX=2;
  - parity-type encodings EVEN=0, ODD=1.
- Sub-module uart_rx_sampler contains:
  - the sample-point compare against edge_counter and prescaler;
  - the sample register(s), including the majority vote under the macro;
  - a sample_done strobe output.
- The FSM, shift register, parity/stop check and output registers stay in uart_rx_ctrl.
- The edge/bit counter is instantiated alongside, at the parent level.

Test Plan:
1. prescaler=8, PAR_EN=0, frame 0xA5 → data_valid high for 1 cycle after edge t+80, P_DATA=0xA5, no errors, counter_en low afterwards.
2. prescaler=16, PAR_EN=1, PAR_TYP=0, data 0x3C with parity bit driven 1 → par_err pulse after edge t+176, data_valid=0, P_DATA keeps its previous value.
3. prescaler=8, PAR_EN=0, data 0x5A with stop bit 0 → stp_err pulse after edge t+80, data_valid=0.
4. prescaler=16, RX_IN low for 2 cycles then high → START ends at edge t+16, returns to IDLE, no pulses; a valid frame that follows is received correctly.
5. RST=1 for one cycle during data bit 4 → next cycle state=IDLE, counter_en=0, all pulses 0; the following frame 0xFF is received correctly.
6. prescaler=32, PAR_EN=1, PAR_TYP=1, frames 0x00 and 0xFF back-to-back with the second start bit immediately after the stop bit → two data_valid pulses, P_DATA=0x00 then 0xFF, no errors. With the macro defined, a single-cycle glitch at SP inside a data bit must not corrupt the data.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART RX frame controller.
// Holds the FSM state enum, bit-index constants and parity encodings.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int START_IDX      = 1;
  localparam int FIRST_DATA_IDX = 2;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: mid-bit sampler for the UART RX path.
// Ports: i_clk, i_rst, i_rx, i_prescaler, i_edge_cnt in;
//        o_sample (held bit value), o_done (one-cycle strobe) out.
// Macro UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote at SP-1/SP/SP+1.
module uart_rx_sampler #(
  parameter int PRESC_W = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rx,
  input  logic [PRESC_W-1:0] i_prescaler,
  input  logic [PRESC_W-1:0] i_edge_cnt,
  output logic               o_sample,
  output logic               o_done
);
  import uart_rx_pkg::*;

  logic [PRESC_W-1:0] w_sp;
  logic               r_sample;
  logic               r_done;

  assign w_sp     = i_prescaler >> 1;
  assign o_sample = r_sample;
  assign o_done   = r_done;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] w_sp_m1;
  logic [PRESC_W-1:0] w_sp_p1;
  logic               r_s0;
  logic               r_s1;

  assign w_sp_m1 = w_sp - ONE;
  assign w_sp_p1 = w_sp + ONE;

  // The third vote is taken live at SP+1 and resolved on that edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s0     <= 1'b1;
      r_s1     <= 1'b1;
      r_sample <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_edge_cnt == w_sp_m1) r_s0 <= i_rx;
      if (i_edge_cnt == w_sp)    r_s1 <= i_rx;
      if (i_edge_cnt == w_sp_p1) begin
        r_sample <= maj3(r_s0, r_s1, i_rx);
        r_done   <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sample <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_edge_cnt == w_sp) begin
        r_sample <= i_rx;
        r_done   <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame controller (start/data/parity/stop).
// In: CLK, RST, RX_IN, PAR_EN, PAR_TYP, prescaler, edge_counter,
//     bit_counter. Out: counter_en, P_DATA, data_valid, par_err,
//     stp_err, busy. Macro UART_RX_MAJORITY_VOTE_EN: voted sampling.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6,
  parameter int BCNT_W     = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESC_W-1:0]    prescaler,
  input  logic [PRESC_W-1:0]    edge_counter,
  input  logic [BCNT_W-1:0]     bit_counter,
  output logic                  counter_en,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);
  import uart_rx_pkg::*;

  localparam logic [BCNT_W-1:0] LAST_BIT =
    BCNT_W'(FIRST_DATA_IDX + DATA_WIDTH - 1);

  rx_state_e             r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_pdata;
  logic                  r_dv;
  logic                  r_pe;
  logic                  r_se;
  logic                  r_par_flag;

  logic w_bit;
  logic w_done;
  logic w_eob;
  logic w_par_exp;

  uart_rx_sampler #(
    .PRESC_W (PRESC_W)
  ) u_sampler (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_rx        (RX_IN),
    .i_prescaler (prescaler),
    .i_edge_cnt  (edge_counter),
    .o_sample    (w_bit),
    .o_done      (w_done)
  );

  assign w_eob     = (edge_counter == prescaler);
  assign w_par_exp = (^r_shift) ^ (PAR_TYP == ODD);

  assign counter_en = (r_state != IDLE);
  assign busy       = (r_state != IDLE);
  assign P_DATA     = r_pdata;
  assign data_valid = r_dv;
  assign par_err    = r_pe;
  assign stp_err    = r_se;

  // The sampled bit is always resolved before EOB, so EOB
  // decisions read the held sample directly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_pdata    <= '0;
      r_dv       <= 1'b0;
      r_pe       <= 1'b0;
      r_se       <= 1'b0;
      r_par_flag <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      r_pe <= 1'b0;
      r_se <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_par_flag <= 1'b0;
          if (!RX_IN) r_state <= START;
        end
        START: begin
          if (w_eob) r_state <= w_bit ? IDLE : DATA;
        end
        DATA: begin
          if (w_done)
            r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
          if (w_eob && bit_counter == LAST_BIT)
            r_state <= PAR_EN ? PARITY : STOP;
        end
        PARITY: begin
          if (w_eob) begin
            r_par_flag <= (w_bit != w_par_exp);
            r_state    <= STOP;
          end
        end
        STOP: begin
          if (w_eob) begin
            r_state <= IDLE;
            r_se    <= ~w_bit;
            r_pe    <= r_par_flag;
            if (w_bit && !r_par_flag) begin
              r_pdata <= r_shift;
              r_dv    <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: self-checking bench for uart_rx_ctrl.
// Models the edge/bit counter and scores pulses against a queue.
module tb_uart_rx_ctrl;

  localparam int DW = 8;
  localparam int PW = 6;
  localparam int BW = 4;

  typedef struct {
    logic          dv;
    logic          pe;
    logic          se;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          par_en;
  logic          par_typ;
  logic [PW-1:0] presc;
  logic [PW-1:0] ec;
  logic [BW-1:0] bc;
  logic          counter_en;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;
  logic          busy;

  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] last_good = '0;
  exp_t          q[$];

  uart_rx_ctrl #(
    .DATA_WIDTH (DW),
    .PRESC_W    (PW),
    .BCNT_W     (BW)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .RX_IN        (rx),
    .PAR_EN       (par_en),
    .PAR_TYP      (par_typ),
    .prescaler    (presc),
    .edge_counter (ec),
    .bit_counter  (bc),
    .counter_en   (counter_en),
    .P_DATA       (p_data),
    .data_valid   (data_valid),
    .par_err      (par_err),
    .stp_err      (stp_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Edge/bit counter: held at 1/1 while disabled.
  always @(posedge clk) begin
    if (rst || !counter_en) begin
      ec <= PW'(1);
      bc <= BW'(1);
    end else if (ec == presc) begin
      ec <= PW'(1);
      bc <= bc + BW'(1);
    end else begin
      ec <= ec + PW'(1);
    end
  end

  // Pulse monitor / scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (data_valid || par_err || stp_err)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d dv=%b pe=%b se=%b",
                 cyc, data_valid, par_err, stp_err);
      end else begin
        e = q.pop_front();
        if ({data_valid, par_err, stp_err, p_data} !==
            {e.dv, e.pe, e.se, e.data}) begin
          errors++;
          $display("FAIL pulse_value got dv%b pe%b se%b d=%h want dv%b pe%b se%b d=%h",
                   data_valid, par_err, stp_err, p_data,
                   e.dv, e.pe, e.se, e.data);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL pulse_time got cyc=%0d want cyc=%0d",
                   cyc, e.cyc);
        end
        checks++;
        if (counter_en !== 1'b0) begin
          errors++;
          $display("FAIL cen_after_frame got %b want 0", counter_en);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && q.size() != 0; i++)
      @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending want 0", name, q.size());
      q.delete();
    end
  endtask

  // Drives one frame bit-by-bit (p cycles per bit) and queues
  // the expected pulse. skew=1 when the DUT still sits in STOP
  // as the start bit begins.
  task automatic send_frame(
    input logic [DW-1:0] d,
    input int            p,
    input logic          pe,
    input logic          pt,
    input logic          par_inv,
    input logic          stop_bit,
    input int            skew,
    input int            glitch_k
  );
    logic bits[$];
    exp_t e;
    int   t;
    logic perr;
    presc   = PW'(p);
    par_en  = pe;
    par_typ = pt;
    t = cyc + 1 + skew;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back((^d) ^ pt ^ par_inv);
    bits.push_back(stop_bit);
    perr   = pe & par_inv;
    e.dv   = stop_bit & ~perr;
    e.pe   = perr;
    e.se   = ~stop_bit;
    e.data = e.dv ? d : last_good;
    e.cyc  = t + (DW + 2 + int'(pe)) * p;
    if (e.dv) last_good = d;
    q.push_back(e);
    for (int k = 0; k < bits.size(); k++) begin
      for (int j = 0; j < p; j++) begin
        rx = (k == glitch_k && j == p / 2) ? ~bits[k] : bits[k];
        @(negedge clk);
      end
    end
    rx = 1'b1;
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    rx      = 1'b1;
    par_en  = 1'b0;
    par_typ = 1'b0;
    presc   = PW'(8);
    idle(3);
    checks++;
    if (p_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_pdata got %h want 00", p_data);
    end
    checks++;
    if ({data_valid, par_err, stp_err} !== 3'b000) begin
      errors++;
      $display("FAIL rst_pulses got %b want 000",
               {data_valid, par_err, stp_err});
    end
    checks++;
    if ({busy, counter_en} !== 2'b00) begin
      errors++;
      $display("FAIL rst_busy got %b want 00", {busy, counter_en});
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1);
    drain("basic");
    idle(3);
  endtask

  task automatic test_parity_err;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 0, -1);
    drain("parity_err");
    idle(3);
  endtask

  task automatic test_stop_err;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
    drain("stop_err");
    idle(3);
  endtask

  task automatic test_glitch;
    int t;
    presc  = PW'(16);
    par_en = 1'b0;
    t  = cyc + 1;
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    for (int i = 0; i < 40 && cyc < t + 15; i++)
      @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_t15 got %b want 1", busy);
    end
    @(negedge clk);
    checks++;
    if ({busy, counter_en} !== 2'b00) begin
      errors++;
      $display("FAIL glitch_idle_t16 got %b want 00",
               {busy, counter_en});
    end
    idle(3);
    send_frame(8'h96, 16, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1);
    drain("glitch_next");
    idle(3);
  endtask

  task automatic test_mid_reset;
    logic [DW-1:0] d;
    d      = 8'h33;
    presc  = PW'(8);
    par_en = 1'b0;
    rx     = 1'b0;
    idle(8);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      idle(8);
    end
    rx = d[4];
    idle(4);
    checks++;
    if (busy !== 1'b1 || bc !== BW'(6)) begin
      errors++;
      $display("FAIL midrst_pre got busy=%b bc=%0d want 1/6", busy, bc);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_good = '0;
    checks++;
    if ({busy, counter_en} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_idle got %b want 00", {busy, counter_en});
    end
    checks++;
    if ({data_valid, par_err, stp_err} !== 3'b000 ||
        p_data !== 8'h00) begin
      errors++;
      $display("FAIL midrst_out got %b d=%h want 000 d=00",
               {data_valid, par_err, stp_err}, p_data);
    end
    rx = 1'b1;
    idle(4);
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1);
    drain("midrst_next");
    idle(3);
  endtask

  task automatic test_back_to_back;
    send_frame(8'h00, 32, 1'b1, 1'b1, 1'b0, 1'b1, 0, -1);
    send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1, -1);
    drain("b2b");
    idle(3);
  endtask

`ifdef UART_RX_MAJORITY_VOTE_EN
  task automatic test_vote;
    send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b0, 1'b1, 0, 3);
    drain("vote");
    idle(3);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_stop_err();
    test_glitch();
    test_mid_reset();
    test_back_to_back();
`ifdef UART_RX_MAJORITY_VOTE_EN
    test_vote();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
